// File: rtl/wand_bus_tx_if.sv
// Bundle of the transmitter's handshake and line signals.
// The slave side is the transmitter. The master side is the user logic together with
// the line readback.
interface wand_bus_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              bus_in;
  logic              bus_drive_low;
  logic              ready;
  logic              busy;
  logic              done;
  logic              lost;
  logic              err;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;

  modport master (
    output start, data_in, bus_in,
    input  bus_drive_low, ready, busy, done, lost, err, rx_valid, rx_data
  );

  modport slave (
    input  start, data_in, bus_in,
    output bus_drive_low, ready, busy, done, lost, err, rx_valid, rx_data
  );
endinterface

// File: rtl/wand_bus_tx.sv
// Serial transmitter for a shared wired-AND (open-drain) line.
// A frame is one start bit (0), then DATA_W payload bits sent MSB-first, then one
// stop bit (1). The node reads back the resolved line and arbitrates bit by bit.
// A node that loses arbitration stops driving and keeps receiving the winner's frame.
module wand_bus_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  wand_bus_tx_if.slave bus
);

  localparam int CYC_W  = $clog2(BIT_CYCLES);
  localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int IDLE_W = $clog2(BIT_CYCLES + 1);

  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_FULL = IDLE_W'(BIT_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_TOP   = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_LOST
  } state_t;

  state_t              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                lstop_q, lstop_d;   // in LOST: the data bits are done, the stop bit is next
  logic                drive_q, drive_d;
  logic                done_q, done_d;
  logic                lost_q, lost_d;
  logic                err_q, err_d;
  logic                rxv_q, rxv_d;
  logic                busy_q, busy_d;
  logic                ready_q, ready_d;

  logic                sample;
  logic                bit_end;
  logic                tx_bit;

  // Only a clean 1 reads as recessive. X and Z resolve to the dominant 0.
  assign sample  = (bus.bus_in === 1'b1);
  assign bit_end = (cyc_q == CYC_LAST);
  assign tx_bit  = tx_q[idx_q];

  // Registers. On async reset the line is released at once, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      idx_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      idle_q  <= '0;
      lstop_q <= 1'b0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      lost_q  <= 1'b0;
      err_q   <= 1'b0;
      rxv_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      idle_q  <= idle_d;
      lstop_q <= lstop_d;
      drive_q <= drive_d;
      done_q  <= done_d;
      lost_q  <= lost_d;
      err_q   <= err_d;
      rxv_q   <= rxv_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  // Next state, bit timing, arbitration and the registered outputs.
  always_comb begin
    state_d = state_q;
    cyc_d   = bit_end ? '0 : cyc_q + CYC_W'(1);
    idx_d   = idx_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    lstop_d = lstop_q;
    drive_d = drive_q;
    done_d  = 1'b0;
    lost_d  = 1'b0;
    err_d   = 1'b0;
    rxv_d   = 1'b0;

    // Count consecutive clean-high samples in every state. The count saturates at one bit time.
    if (!sample)
      idle_d = '0;
    else if (idle_q == IDLE_FULL)
      idle_d = idle_q;
    else
      idle_d = idle_q + IDLE_W'(1);

    unique case (state_q)
      S_IDLE: begin
        cyc_d   = '0;
        drive_d = 1'b0;
        if (bus.start && ready_q) begin
          tx_d    = bus.data_in;
          rx_d    = '0;
          lstop_d = 1'b0;
          drive_d = 1'b1;              // start bit is dominant
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          if (sample) begin
            // The line stayed high while we pulled it low: the line is faulty.
            err_d   = 1'b1;
            drive_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = IDX_TOP;
            drive_d = ~tx_q[DATA_W-1];
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (bit_end) begin
          rx_d = {rx_q[DATA_W-2:0], sample};
          if (tx_bit && !sample) begin
            // Another node is dominant: stop driving and keep counting bits as a receiver.
            lost_d  = 1'b1;
            drive_d = 1'b0;
            state_d = S_LOST;
            if (idx_q == '0)
              lstop_d = 1'b1;
            else
              idx_d = idx_q - IDX_ONE;
          end else if (!tx_bit && sample) begin
            err_d   = 1'b1;
            drive_d = 1'b0;
            state_d = S_IDLE;
          end else if (idx_q == '0) begin
            drive_d = 1'b0;            // stop bit is recessive
            state_d = S_STOP;
          end else begin
            idx_d   = idx_q - IDX_ONE;
            drive_d = ~tx_q[idx_q - IDX_ONE];
          end
        end
      end

      S_STOP: begin
        drive_d = 1'b0;
        if (bit_end) begin
          state_d = S_IDLE;
          if (sample)
            done_d = 1'b1;
          else
            err_d = 1'b1;
        end
      end

      S_LOST: begin
        drive_d = 1'b0;
        if (bit_end) begin
          if (lstop_q) begin
            state_d = S_IDLE;
            if (sample)
              rxv_d = 1'b1;
            else
              err_d = 1'b1;
          end else begin
            rx_d = {rx_q[DATA_W-2:0], sample};
            if (idx_q == '0)
              lstop_d = 1'b1;
            else
              idx_d = idx_q - IDX_ONE;
          end
        end
      end

      default: begin
        drive_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE) && (idle_d == IDLE_FULL);
  end

  assign bus.bus_drive_low = drive_q;
  assign bus.ready         = ready_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lost          = lost_q;
  assign bus.err           = err_q;
  assign bus.rx_valid      = rxv_q;
  assign bus.rx_data       = rx_q;

endmodule

// File: tb/tb_wand_bus_tx.sv
// Bench for wand_bus_tx. Two nodes share one wired-AND line. Expected pulses are
// queued per node when a frame is launched. They are popped and compared when the
// node pulses done, lost, err or rx_valid.
module tb_wand_bus_tx;

  localparam int DW = 8;
  localparam int BC = 4;

  localparam logic [3:0] K_DONE = 4'b1000;
  localparam logic [3:0] K_LOST = 4'b0100;
  localparam logic [3:0] K_ERR  = 4'b0010;
  localparam logic [3:0] K_RXV  = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    logic [7:0] rx;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle_n = 0;         // number of rising edges so far
  logic [1:0] mode = 2'd0;   // 0: resolved line, 1: forced low, 2: forced X
  logic line;

  int checks = 0;
  int errors = 0;

  ev_t exp_a[$];
  ev_t exp_b[$];

  wand_bus_tx_if #(.DATA_W(DW)) if_a ();
  wand_bus_tx_if #(.DATA_W(DW)) if_b ();

  wand_bus_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  wand_bus_tx #(.DATA_W(DW), .BIT_CYCLES(BC)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  // The wired-AND line is low while any node pulls it low. Fault modes override it.
  assign line = (mode == 2'd1) ? 1'b0 :
                (mode == 2'd2) ? 1'bx :
                ~(if_a.bus_drive_low | if_b.bus_drive_low);
  assign if_a.bus_in = line;
  assign if_b.bus_in = line;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Match one node's pulses against the front of its queue. The cycle is in
  // accept-relative terms: at a falling edge, the current cycle is cycle_n+1.
  task automatic mon(input int id, input logic [3:0] p, input logic [7:0] rx);
    ev_t e;
    bit  have;
    if (p != 4'b0) begin
      have = 1'b0;
      if (id == 0 && exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
      if (id == 1 && exp_b.size() > 0) begin e = exp_b.pop_front(); have = 1'b1; end
      check($sformatf("n%0d_event_expected pulses=%b", id, p), {31'b0, have}, 32'd1);
      if (have) begin
        check($sformatf("n%0d_kind", id), {28'b0, p}, {28'b0, e.kind});
        check($sformatf("n%0d_cycle", id), 32'(cycle_n + 1), 32'(e.cyc));
        if ((e.kind & (K_DONE | K_RXV)) != 4'b0)
          check($sformatf("n%0d_rx_data", id), {24'b0, rx}, {24'b0, e.rx});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon(0, {if_a.done, if_a.lost, if_a.err, if_a.rx_valid}, if_a.rx_data);
    mon(1, {if_b.done, if_b.lost, if_b.err, if_b.rx_valid}, if_b.rx_data);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!(if_a.ready && if_b.ready) && k < 60) begin
      step();
      k++;
    end
    check("wait_ready", {30'b0, if_a.ready, if_b.ready}, 32'd3);
  endtask

  function automatic ev_t mk(input logic [3:0] kind, input logic [7:0] rx, input int cyc);
    ev_t e;
    e.kind = kind;
    e.rx   = rx;
    e.cyc  = cyc;
    return e;
  endfunction

  initial begin
    int t;
    logic [9:0] frame;
    logic [7:0] d;

    if_a.start = 1'b0; if_a.data_in = '0;
    if_b.start = 1'b0; if_b.data_in = '0;

    // Reset state
    steps(2);
    check("rst_drive", {31'b0, if_a.bus_drive_low}, 32'd0);
    check("rst_busy_ready", {30'b0, if_a.busy, if_a.ready}, 32'd0);
    check("rst_pulses", {28'b0, if_a.done, if_a.lost, if_a.err, if_a.rx_valid}, 32'd0);
    check("rst_rx_data", {24'b0, if_a.rx_data}, 32'd0);
    rst = 1'b0;
    steps(3);
    check("rdy_after3", {31'b0, if_a.ready}, 32'd0);
    step();
    check("rdy_after4", {31'b0, if_a.ready}, 32'd1);
    $display("reset: released, ready after %0d clean clocks", BC);

    // Solo frame A5 on node A
    d = 8'hA5;
    if_a.data_in = d; if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    t = cycle_n;
    check("solo_busy", {31'b0, if_a.busy}, 32'd1);
    exp_a.push_back(mk(K_DONE, 8'hA5, t + 41));
    frame = {1'b0, d, 1'b1};
    for (int i = 0; i < 40; i++) begin
      check($sformatf("solo_line_c%0d", i + 1), {31'b0, line}, {31'b0, frame[9 - i / 4]});
      step();
    end
    check("solo_busy_fall", {31'b0, if_a.busy}, 32'd0);
    check("solo_queue", 32'(exp_a.size()), 32'd0);
    $display("solo: A sent %h, done at accept+41", d);

    // Arbitration: A=3C against B=35. A loses at data bit 3.
    wait_ready();
    if_a.data_in = 8'h3C; if_a.start = 1'b1;
    if_b.data_in = 8'h35; if_b.start = 1'b1;
    step();
    if_a.start = 1'b0; if_b.start = 1'b0;
    t = cycle_n;
    exp_a.push_back(mk(K_LOST, 8'h00, t + 25));
    exp_a.push_back(mk(K_RXV, 8'h35, t + 41));
    exp_b.push_back(mk(K_DONE, 8'h35, t + 41));
    steps(42);
    check("arb_queue_a", 32'(exp_a.size()), 32'd0);
    check("arb_queue_b", 32'(exp_b.size()), 32'd0);
    $display("arbitration: A 3C lost to B 35");

    // X readback during a recessive data bit: A goes to LOST and then receives 7F.
    wait_ready();
    if_a.data_in = 8'hFF; if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    t = cycle_n;
    exp_a.push_back(mk(K_LOST, 8'h00, t + 9));
    exp_a.push_back(mk(K_RXV, 8'h7F, t + 41));
    steps(4);
    mode = 2'd2;
    steps(4);
    mode = 2'd0;
    check("x_lost_busy", {31'b0, if_a.busy}, 32'd1);
    check("x_lost_drive", {31'b0, if_a.bus_drive_low}, 32'd0);
    steps(34);
    check("x_queue", 32'(exp_a.size()), 32'd0);
    $display("x readback: A entered LOST and received 7F");

    // Stop bit forced low: err and no done.
    wait_ready();
    if_a.data_in = 8'hA5; if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    t = cycle_n;
    exp_a.push_back(mk(K_ERR, 8'h00, t + 41));
    steps(36);
    mode = 2'd1;
    steps(4);
    mode = 2'd0;
    check("stop_idle", {31'b0, if_a.busy}, 32'd0);
    steps(2);
    check("stop_queue", 32'(exp_a.size()), 32'd0);
    $display("stop fault: A reported err");

    // Async reset in the middle of DATA
    wait_ready();
    if_a.data_in = 8'h00; if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    steps(8);
    check("mid_drive_before", {31'b0, if_a.bus_drive_low}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_drive_async", {31'b0, if_a.bus_drive_low}, 32'd0);
    check("mid_busy_ready", {30'b0, if_a.busy, if_a.ready}, 32'd0);
    check("mid_rx_data", {24'b0, if_a.rx_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    steps(3);
    check("mid_rdy_after3", {31'b0, if_a.ready}, 32'd0);
    step();
    check("mid_rdy_after4", {31'b0, if_a.ready}, 32'd1);
    $display("reset mid-frame: line released before the next edge");

    // Busy line: start is refused.
    mode = 2'd1;
    steps(3);
    check("busyln_ready", {31'b0, if_a.ready}, 32'd0);
    if_a.data_in = 8'h55; if_a.start = 1'b1;
    step();
    if_a.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("busyln_state%0d", i), {30'b0, if_a.busy, if_a.bus_drive_low}, 32'd0);
      step();
    end
    mode = 2'd0;
    steps(6);
    check("final_queue_a", 32'(exp_a.size()), 32'd0);
    check("final_queue_b", 32'(exp_b.size()), 32'd0);
    $display("busy line: start refused");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
